mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline, directly downstream of EX.
//  - Registers the EX->MEM bus and applies stall/bubble control.
//  - Aligns and sign- or zero-extends load data returned by the synchronous data SRAM.
//  - Holds that load data across MEM stalls.
//  - Flags misaligned loads.
//  - Drives the MEM->WB bus and the MEM->ID forwarding bus.
// PARAMETERS
//  EX_TO_MEM_WD   79  input bus: {ld_type[2:0],ex_pc[31:0],data_ram_en,data_ram_wen[3:0],sel_rf_res,rf_we,rf_waddr[4:0],ex_result[31:0]}
//  MEM_TO_WB_WD   70  output bus: {mem_pc[31:0],rf_we,rf_waddr[4:0],rf_wdata[31:0]}
//  STALL_WD       6   stall vector width (StallBus)
// PORTS
//  clk              in   1             clock
//  rst              in   1             reset, synchronous, active-high
//  stall            in   STALL_WD      stall[3]=MEM input reg, stall[4]=WB input reg; 1=Stop
//  ex_to_mem_bus    in   EX_TO_MEM_WD  EX result bus
//  data_sram_rdata  in   32            SRAM read data, valid in first MEM cycle of an entry
//  mem_to_wb_bus    out  MEM_TO_WB_WD  to WB register
//  mem_to_id_bus    out  38            {rf_we,rf_waddr,rf_wdata} forwarding to ID
//  mem_ale          out  1             misaligned-load flag for current entry
// BEHAVIOUR
//  - Input register bus_r:
//    - rst: 0.
//    - stall[3]=Stop and stall[4]=NoStop: bubble (0).
//    - stall[3]=NoStop: load ex_to_mem_bus.
//    - Otherwise: hold.
//  - fresh flag:
//    - rst: 0.
//    - Set to 1 on any cycle bus_r loads a new entry; cleared on hold or bubble.
//  - rdata_hold:
//    - rst: 0.
//    - Captures data_sram_rdata when fresh=1.
//    - ld_data = fresh ? data_sram_rdata : rdata_hold.
//    - Load data therefore stays stable for the entire MEM stall, even if the SRAM output changes.
//  - Load extraction applies when sel_rf_res=1. Addressing: a=ex_result[1:0], little-endian lanes.
//    - ld_type 000 LW:  ld_data.
//    - ld_type 001 LB:  sign-extend byte lane a (a=0 -> [7:0] .. a=3 -> [31:24]).
//    - ld_type 010 LBU: zero-extend byte lane a.
//    - ld_type 011 LH:  sign-extend half (a[1]=0 -> [15:0], 1 -> [31:16]).
//    - ld_type 100 LHU: zero-extend half.
//    - Other codes: treat as LW.
//  - rf_wdata = sel_rf_res ? extracted load : ex_result.
//  - mem_ale, combinational from bus_r:
//    - Asserted when sel_rf_res=1 and (LW with a!=0, or LH/LHU with a[0]=1).
//    - When mem_ale=1, rf_we in both output buses is forced to 0.
//  - Stores pass through with rf_we as given by the input bus (normally 0). No write path here; EX drives the store.
//  - Latency: outputs are combinational from bus_r, so each result appears 1 cycle after the EX handoff.
//  - Bubble entry: all-zero bus_r, so rf_we=0, mem_ale=0, mem_pc=0.
//  - Reset mid-stall: bus_r, fresh and rdata_hold all clear in the reset cycle. Outputs are all 0 the next cycle.
//  - Simultaneous stall[3]=Stop and stall[4]=Stop: full hold. fresh goes 0 after the first cycle.
// TESTING
//  1. LB, ex_result=0x1000_0001, rdata=0x1234_80FF -> rf_wdata=0xFFFF_FF80, rf_we=1. LBU same -> 0x0000_0080.
//  2. LH, addr ..02, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LW addr ..00 -> 0x8001_7FFF.
//  3. Load enters, stall[3]=stall[4]=1 for 3 cycles, rdata changes to 0xDEAD_BEEF in cycle 2 -> rf_wdata stays the first-cycle value.
//  4. stall[3]=1, stall[4]=0 -> next cycle bus_r=0, mem_to_wb_bus=0, mem_to_id_bus=0.
//  5. LW addr 0x...02 -> mem_ale=1 and rf_we=0 on both buses. LH addr ..01 -> mem_ale=1. LB addr ..03 -> mem_ale=0.
//  6. rst asserted during a held load -> next cycle all outputs 0. A non-load ALU entry (sel_rf_res=0) then passes ex_result unchanged.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: registers the EX result, extracts load data from the data SRAM,
// flags misaligned loads and feeds the WB register and ID forwarding.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_bus,
  output logic                    mem_ale
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic                    fresh;
  logic [31:0]             rdata_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r <= '0;
      fresh <= 1'b0;
    end else if (!stall[3]) begin
      bus_r <= ex_to_mem_bus;
      fresh <= 1'b1;
    end else if (!stall[4]) begin
      bus_r <= '0;
      fresh <= 1'b0;
    end else begin
      fresh <= 1'b0;
    end
  end

  // SRAM data is only valid in the first MEM cycle; keep it for stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_hold <= '0;
    end else if (fresh) begin
      rdata_hold <= data_sram_rdata;
    end
  end

  logic [2:0]  ld_type;
  logic [31:0] mem_pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  assign {ld_type, mem_pc, data_ram_en, data_ram_wen,
          sel_rf_res, rf_we, rf_waddr, ex_result} = bus_r;

  logic unused_bits;
  assign unused_bits = ^{data_ram_en, data_ram_wen,
                         stall[STALL_WD-1:5], stall[2:0]};

  logic [1:0]  addr;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        is_lb;
  logic        is_lbu;
  logic        is_lh;
  logic        is_lhu;

  assign addr    = ex_result[1:0];
  assign ld_data = fresh ? data_sram_rdata : rdata_hold;
  assign ld_half = addr[1] ? ld_data[31:16] : ld_data[15:0];
  assign is_lb   = ld_type == LD_LB;
  assign is_lbu  = ld_type == LD_LBU;
  assign is_lh   = ld_type == LD_LH;
  assign is_lhu  = ld_type == LD_LHU;

  always_comb begin
    ld_byte = ld_data[7:0];
    unique case (addr)
      2'd0: ld_byte = ld_data[7:0];
      2'd1: ld_byte = ld_data[15:8];
      2'd2: ld_byte = ld_data[23:16];
      2'd3: ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
  end

  always_comb begin
    ld_ext = ld_data;
    unique case (1'b1)
      is_lb:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      is_lbu:  ld_ext = {24'h0, ld_byte};
      is_lh:   ld_ext = {{16{ld_half[15]}}, ld_half};
      is_lhu:  ld_ext = {16'h0, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

  // Unknown load codes behave as LW, alignment check included.
  logic half_ld;
  logic word_ld;
  assign half_ld = is_lh | is_lhu;
  assign word_ld = ~(is_lb | is_lbu | half_ld) & (ld_type != LD_LW | 1'b1);

  always_comb begin
    mem_ale = 1'b0;
    if (sel_rf_res) begin
      mem_ale = (word_ld & (addr != 2'b00)) | (half_ld & addr[0]);
    end
  end

  logic        wb_we;
  logic [31:0] rf_wdata;
  assign wb_we    = rf_we & ~mem_ale;
  assign rf_wdata = sel_rf_res ? ld_ext : ex_result;

  assign mem_to_wb_bus = {mem_pc, wb_we, rf_waddr, rf_wdata};
  assign mem_to_id_bus = {wb_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/stall/reset cases, then random traffic
// against a field-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;
  logic        mem_ale;

  int n_checks = 0;
  int n_err    = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus),
    .mem_ale         (mem_ale)
  );

  always #5 clk = ~clk;

  // Reference: the entry in MEM, whether this is its first cycle,
  // and the load word captured during that first cycle.
  logic [78:0] m_bus   = '0;
  bit          m_first = 1'b0;
  logic [31:0] m_ld    = '0;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [78:0] mk(input logic [2:0] lt,
                                     input logic [31:0] pc,
                                     input logic sel, input logic we,
                                     input logic [4:0] wa,
                                     input logic [31:0] res);
    return {lt, pc, sel, 4'h0, sel, we, wa, res};
  endfunction

  function automatic logic [5:0] st(input logic s3, input logic s4);
    return {1'b0, s4, s3, 3'b000};
  endfunction

  task automatic model_update(input logic r, input logic [5:0] s,
                              input logic [78:0] b);
    if (r) begin
      m_bus = '0; m_first = 0; m_ld = '0;
    end else begin
      if (m_first) m_ld = data_sram_rdata;
      if (!s[3]) begin
        m_bus = b; m_first = 1;
      end else if (!s[4]) begin
        m_bus = '0; m_first = 0;
      end else begin
        m_first = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0]  lt;
    logic [31:0] pc, res, ld, val;
    logic        sel, we, ale;
    logic [4:0]  wa;
    logic [7:0]  bv;
    logic [15:0] hv;
    int          a;
    lt  = m_bus[78:76];
    pc  = m_bus[75:44];
    sel = m_bus[38];
    we  = m_bus[37];
    wa  = m_bus[36:32];
    res = m_bus[31:0];
    a   = int'(res[1:0]);
    ld  = m_first ? data_sram_rdata : m_ld;
    bv  = 8'((ld >> (8 * a)) & 32'hFF);
    hv  = 16'((ld >> (16 * (a / 2))) & 32'hFFFF);
    case (lt)
      3'd1:    val = {{24{bv[7]}}, bv};
      3'd2:    val = {24'h0, bv};
      3'd3:    val = {{16{hv[15]}}, hv};
      3'd4:    val = {16'h0, hv};
      default: val = ld;
    endcase
    if (lt == 3'd1 || lt == 3'd2) ale = 0;
    else if (lt == 3'd3 || lt == 3'd4) ale = sel && (a % 2 == 1);
    else ale = sel && (a != 0);
    if (ale) we = 0;
    if (!sel) val = res;
    check({tag, "_wb"}, 80'(mem_to_wb_bus), 80'({pc, we, wa, val}));
    check({tag, "_id"}, 80'(mem_to_id_bus), 80'({we, wa, val}));
    check({tag, "_ale"}, 80'(mem_ale), 80'(ale));
  endtask

  // Drive controls for the next edge; rdata is what SRAM returns after it.
  task automatic tick(input string tag, input logic r, input logic [5:0] s,
                      input logic [78:0] b, input logic [31:0] rd);
    rst = r; stall = s; ex_to_mem_bus = b;
    @(posedge clk);
    model_update(r, s, b);
    #1 data_sram_rdata = rd;
    #1 check_all(tag);
  endtask

  logic [78:0] ld_bus;

  initial begin
    rst = 1; stall = '0; ex_to_mem_bus = '0; data_sram_rdata = '0;
    tick("rst", 1, st(0, 0), '0, 32'h0);
    check("rst_wb", 80'(mem_to_wb_bus), 80'h0);
    check("rst_ale", 80'(mem_ale), 80'h0);

    tick("lb", 0, st(0, 0), mk(3'd1, 32'h400, 1, 1, 5'd3, 32'h1000_0001),
         32'h1234_80FF);
    check("lb_val", 80'(mem_to_wb_bus[31:0]), 80'hFFFF_FF80);
    check("lb_we", 80'(mem_to_wb_bus[37]), 80'h1);
    tick("lbu", 0, st(0, 0), mk(3'd2, 32'h404, 1, 1, 5'd3, 32'h1000_0001),
         32'h1234_80FF);
    check("lbu_val", 80'(mem_to_wb_bus[31:0]), 80'h0000_0080);

    tick("lh", 0, st(0, 0), mk(3'd3, 32'h408, 1, 1, 5'd4, 32'h1000_0002),
         32'h8001_7FFF);
    check("lh_val", 80'(mem_to_wb_bus[31:0]), 80'hFFFF_8001);
    tick("lhu", 0, st(0, 0), mk(3'd4, 32'h40C, 1, 1, 5'd4, 32'h1000_0002),
         32'h8001_7FFF);
    check("lhu_val", 80'(mem_to_wb_bus[31:0]), 80'h0000_8001);
    tick("lw", 0, st(0, 0), mk(3'd0, 32'h410, 1, 1, 5'd5, 32'h1000_0000),
         32'h8001_7FFF);
    check("lw_val", 80'(mem_to_wb_bus[31:0]), 80'h8001_7FFF);

    ld_bus = mk(3'd0, 32'h414, 1, 1, 5'd6, 32'h2000_0000);
    tick("hold0", 0, st(0, 0), ld_bus, 32'h1122_3344);
    tick("hold1", 0, st(1, 1), '0, 32'h1122_3344);
    tick("hold2", 0, st(1, 1), '0, 32'hDEAD_BEEF);
    check("hold2_val", 80'(mem_to_wb_bus[31:0]), 80'h1122_3344);
    tick("hold3", 0, st(1, 1), '0, 32'hDEAD_BEEF);
    check("hold3_val", 80'(mem_to_wb_bus[31:0]), 80'h1122_3344);

    tick("bub", 0, st(1, 0), '0, 32'h5555_5555);
    check("bub_wb", 80'(mem_to_wb_bus), 80'h0);
    check("bub_id", 80'(mem_to_id_bus), 80'h0);

    tick("alew", 0, st(0, 0), mk(3'd0, 32'h418, 1, 1, 5'd7, 32'h3000_0002),
         32'hCAFE_F00D);
    check("alew_ale", 80'(mem_ale), 80'h1);
    check("alew_wbwe", 80'(mem_to_wb_bus[37]), 80'h0);
    check("alew_idwe", 80'(mem_to_id_bus[37]), 80'h0);
    tick("aleh", 0, st(0, 0), mk(3'd3, 32'h41C, 1, 1, 5'd7, 32'h3000_0001),
         32'hCAFE_F00D);
    check("aleh_ale", 80'(mem_ale), 80'h1);
    tick("aleb", 0, st(0, 0), mk(3'd1, 32'h420, 1, 1, 5'd7, 32'h3000_0003),
         32'hCAFE_F00D);
    check("aleb_ale", 80'(mem_ale), 80'h0);

    tick("rsth0", 0, st(0, 0), mk(3'd0, 32'h424, 1, 1, 5'd8, 32'h40),
         32'h0BAD_0BAD);
    tick("rsth1", 0, st(1, 1), '0, 32'h0BAD_0BAD);
    tick("rsth2", 1, st(1, 1), '0, 32'h0BAD_0BAD);
    check("rsth_wb", 80'(mem_to_wb_bus), 80'h0);
    check("rsth_id", 80'(mem_to_id_bus), 80'h0);
    tick("alu", 0, st(0, 0), mk(3'd1, 32'h428, 0, 1, 5'd9, 32'h8765_4323),
         32'hFFFF_FFFF);
    check("alu_val", 80'(mem_to_wb_bus[31:0]), 80'h8765_4323);

    for (int i = 0; i < 400; i++) begin
      logic r;
      logic [5:0] s;
      logic [78:0] b;
      r = ($urandom_range(0, 31) == 0);
      s = st($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      b = mk(3'($urandom_range(0, 7)), $urandom, 1'($urandom),
             1'($urandom), 5'($urandom), $urandom);
      tick("rnd", r, s, b, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
